// File: rtl/tartaruga_pkg.sv
// Shared types and constants for the tartaruga pipeline.
// This file holds the stage-boundary structs seen by the write-back stage.
package tartaruga_pkg;

   localparam int NUM_REGS  = 32;
   localparam int XLEN      = 32;
   localparam int INSTRET_W = 64;

   typedef logic [XLEN-1:0] bus32_t;
   typedef logic [4:0]      reg_addr_t;

   // Decoded instruction fields that survive down to write-back.
   typedef struct packed {
      reg_addr_t rd;
      logic      write_reg;
   } instr_t;

   // Everything the mem stage hands to write-back for one instruction.
   typedef struct packed {
      bus32_t result;
      instr_t instr;
      logic   branch_taken;
      bus32_t branched_pc;
   } mem_to_wb_t;

   // A retiring instruction updates the register file only when it targets a real register.
   function automatic logic writes_reg(input logic commit, input instr_t instr);
      return commit & instr.write_reg & (instr.rd != '0);
   endfunction

endpackage

// File: rtl/wb_stage_regfile.sv
// Architectural register file: one write port, two combinational read ports.
// x0 is never written and always reads as zero.
// Optional feature macro: TARTARUGA_WB_BYPASS_EN (write-through bypass on the read ports).
module regfile
   import tartaruga_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      write_en,
   input  reg_addr_t write_addr,
   input  bus32_t    write_data,
   input  reg_addr_t read_addr1,
   input  reg_addr_t read_addr2,
   output bus32_t    read_data1,
   output bus32_t    read_data2
);

   bus32_t regs [NUM_REGS];

   // Storage update: write_en already excludes x0, so entry 0 stays at its reset value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (write_en) begin
         regs[write_addr] <= write_data;
      end
   end

   // Read port 1: stored value, optionally overridden by the same-cycle write, x0 forced to zero.
   always_comb begin
      read_data1 = regs[read_addr1];
`ifdef TARTARUGA_WB_BYPASS_EN
      if (write_en && (write_addr == read_addr1)) begin
         read_data1 = write_data;
      end
`endif
      if (read_addr1 == '0) begin
         read_data1 = '0;
      end
   end

   // Read port 2: same rules as port 1.
   always_comb begin
      read_data2 = regs[read_addr2];
`ifdef TARTARUGA_WB_BYPASS_EN
      if (write_en && (write_addr == read_addr2)) begin
         read_data2 = write_data;
      end
`endif
      if (read_addr2 == '0) begin
         read_data2 = '0;
      end
   end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: retires the instruction arriving from mem, commits its result
// to the register file, pulses a branch redirect to fetch and counts retirements.
// Optional feature macro: TARTARUGA_WB_BYPASS_EN (handled inside regfile).
module wb_stage
   import tartaruga_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  mem_to_wb_t           mem_to_wb_i,
   input  logic                 valid_i,
   input  logic                 flush_i,
   input  logic [4:0]           rs1_addr_i,
   input  logic [4:0]           rs2_addr_i,
   output logic [XLEN-1:0]      rs1_data_o,
   output logic [XLEN-1:0]      rs2_data_o,
   output logic                 redirect_valid_o,
   output logic [XLEN-1:0]      redirect_pc_o,
   output logic                 commit_valid_o,
   output logic [INSTRET_W-1:0] instret_o
);

   logic                 commit;
   logic                 reg_write;
   logic                 take_branch;
   logic                 redirect_valid;
   bus32_t               redirect_pc;
   logic                 commit_valid;
   logic [INSTRET_W-1:0] instret;

   // A flush squashes the instruction even when valid is high.
   always_comb begin
      commit      = valid_i & ~flush_i;
      reg_write   = writes_reg(commit, mem_to_wb_i.instr);
      take_branch = commit & mem_to_wb_i.branch_taken;
   end

   regfile u_regfile (
      .clk        (clk_i),
      .rst_n      (rstn_i),
      .write_en   (reg_write),
      .write_addr (mem_to_wb_i.instr.rd),
      .write_data (mem_to_wb_i.result),
      .read_addr1 (rs1_addr_i),
      .read_addr2 (rs2_addr_i),
      .read_data1 (rs1_data_o),
      .read_data2 (rs2_data_o)
   );

   // Redirect: one-cycle valid pulse; the target is kept after the pulse ends.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         redirect_valid <= take_branch;
         if (take_branch) begin
            redirect_pc <= mem_to_wb_i.branched_pc;
         end
      end
   end

   // Retirement bookkeeping: registered commit flag and a free-running wrapping counter.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         commit_valid <= 1'b0;
         instret      <= '0;
      end else begin
         commit_valid <= commit;
         instret      <= instret + {{(INSTRET_W-1){1'b0}}, commit};
      end
   end

   assign redirect_valid_o = redirect_valid;
   assign redirect_pc_o    = redirect_pc;
   assign commit_valid_o   = commit_valid;
   assign instret_o        = instret;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
// Expected values are hand-computed; the bypass macro TARTARUGA_WB_BYPASS_EN
// selects the expected same-cycle read value.
module tb_wb_stage;
   import tartaruga_pkg::*;

   logic            clk;
   logic            rstn;
   mem_to_wb_t      mem_to_wb;
   logic            valid;
   logic            flush;
   logic [4:0]      rs1_addr;
   logic [4:0]      rs2_addr;
   logic [31:0]     rs1_data;
   logic [31:0]     rs2_data;
   logic            redirect_valid;
   logic [31:0]     redirect_pc;
   logic            commit_valid;
   logic [63:0]     instret;

   int checks   = 0;
   int failures = 0;

   wb_stage dut (
      .clk_i            (clk),
      .rstn_i           (rstn),
      .mem_to_wb_i      (mem_to_wb),
      .valid_i          (valid),
      .flush_i          (flush),
      .rs1_addr_i       (rs1_addr),
      .rs2_addr_i       (rs2_addr),
      .rs1_data_o       (rs1_data),
      .rs2_data_o       (rs2_data),
      .redirect_valid_o (redirect_valid),
      .redirect_pc_o    (redirect_pc),
      .commit_valid_o   (commit_valid),
      .instret_o        (instret)
   );

   // 10-unit clock period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input logic v, input logic f, input logic [4:0] rd,
                                 input logic wr, input logic [31:0] result,
                                 input logic bt, input logic [31:0] pc);
      valid                   = v;
      flush                   = f;
      mem_to_wb.instr.rd      = rd;
      mem_to_wb.instr.write_reg = wr;
      mem_to_wb.result        = result;
      mem_to_wb.branch_taken  = bt;
      mem_to_wb.branched_pc   = pc;
   endtask

   task automatic idle();
      apply_stimulus(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] exp_same;

      rstn     = 1'b0;
      rs1_addr = 5'd5;
      rs2_addr = 5'd0;
      idle();
      #3;

      // Reset state, before any clock edge
      check_output("reset_redirect_valid", {63'b0, redirect_valid}, 64'd0);
      check_output("reset_redirect_pc", {32'b0, redirect_pc}, 64'd0);
      check_output("reset_commit_valid", {63'b0, commit_valid}, 64'd0);
      check_output("reset_instret", instret, 64'd0);
      check_output("reset_rs1_x5", {32'b0, rs1_data}, 64'd0);

      tick();
      rstn = 1'b1;
      tick();

      // Write x7, check same-cycle read then next-cycle read
      apply_stimulus(1'b1, 1'b0, 5'd7, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
      rs1_addr = 5'd7;
      #1;
`ifdef TARTARUGA_WB_BYPASS_EN
      exp_same = 32'hDEADBEEF;
`else
      exp_same = 32'h0;
`endif
      check_output("same_cycle_rs1_x7", {32'b0, rs1_data}, {32'b0, exp_same});
      tick();
      idle();
      #1;
      check_output("rs1_x7_after_write", {32'b0, rs1_data}, 64'h0000_0000_DEAD_BEEF);
      check_output("commit_valid_after_write", {63'b0, commit_valid}, 64'd1);
      check_output("instret_after_write", instret, 64'd1);
      check_output("no_redirect_after_write", {63'b0, redirect_valid}, 64'd0);

      // Write to x0 is dropped but still retires
      apply_stimulus(1'b1, 1'b0, 5'd0, 1'b1, 32'h0000_1234, 1'b0, 32'h0);
      rs2_addr = 5'd0;
      #1;
      check_output("same_cycle_rs2_x0", {32'b0, rs2_data}, 64'd0);
      tick();
      idle();
      #1;
      check_output("rs2_x0_after_write", {32'b0, rs2_data}, 64'd0);
      check_output("instret_after_x0", instret, 64'd2);
      check_output("rs1_x7_kept", {32'b0, rs1_data}, 64'h0000_0000_DEAD_BEEF);

      // Taken branch: one-cycle pulse, target held afterwards
      apply_stimulus(1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 32'h0000_0100);
      tick();
      idle();
      #1;
      check_output("branch_redirect_valid", {63'b0, redirect_valid}, 64'd1);
      check_output("branch_redirect_pc", {32'b0, redirect_pc}, 64'h100);
      check_output("instret_after_branch", instret, 64'd3);
      tick();
      check_output("branch_pulse_ends", {63'b0, redirect_valid}, 64'd0);
      check_output("branch_pc_holds", {32'b0, redirect_pc}, 64'h100);
      check_output("commit_valid_idle", {63'b0, commit_valid}, 64'd0);
      check_output("instret_idle", instret, 64'd3);

      // JAL-like: register write and redirect on the same edge
      apply_stimulus(1'b1, 1'b0, 5'd1, 1'b1, 32'h0000_0204, 1'b1, 32'h0000_0300);
      tick();
      idle();
      rs2_addr = 5'd1;
      #1;
      check_output("jal_redirect_valid", {63'b0, redirect_valid}, 64'd1);
      check_output("jal_redirect_pc", {32'b0, redirect_pc}, 64'h300);
      check_output("jal_rs2_x1", {32'b0, rs2_data}, 64'h204);
      check_output("instret_after_jal", instret, 64'd4);

      // Flush: preload x3, then a flushed branch+write to x3 must change nothing
      apply_stimulus(1'b1, 1'b0, 5'd3, 1'b1, 32'hAAAA_5555, 1'b0, 32'h0);
      tick();
      apply_stimulus(1'b1, 1'b1, 5'd3, 1'b1, 32'h0000_1111, 1'b1, 32'h0000_0400);
      rs1_addr = 5'd3;
      #1;
      check_output("flush_same_cycle_rs1_x3", {32'b0, rs1_data}, 64'h0000_0000_AAAA_5555);
      tick();
      idle();
      #1;
      check_output("flush_rs1_x3_unchanged", {32'b0, rs1_data}, 64'h0000_0000_AAAA_5555);
      check_output("flush_no_redirect", {63'b0, redirect_valid}, 64'd0);
      check_output("flush_redirect_pc_holds", {32'b0, redirect_pc}, 64'h300);
      check_output("flush_instret_unchanged", instret, 64'd5);
      check_output("flush_commit_valid", {63'b0, commit_valid}, 64'd0);

      // Several distinct writes across both read ports
      for (int i = 8; i < 12; i++) begin
         apply_stimulus(1'b1, 1'b0, 5'(i), 1'b1, 32'h1000_0000 + 32'(i * 17), 1'b0, 32'h0);
         tick();
      end
      idle();
      rs1_addr = 5'd8;
      rs2_addr = 5'd11;
      #1;
      check_output("multi_rs1_x8", {32'b0, rs1_data}, 64'h0000_0000_1000_0088);
      check_output("multi_rs2_x11", {32'b0, rs2_data}, 64'h0000_0000_1000_00BB);
      check_output("instret_after_multi", instret, 64'd9);

      // Asynchronous reset mid-run, checked before any clock edge
      rs1_addr = 5'd3;
      rstn = 1'b0;
      #1;
      check_output("async_reset_instret", instret, 64'd0);
      check_output("async_reset_commit_valid", {63'b0, commit_valid}, 64'd0);
      check_output("async_reset_redirect_pc", {32'b0, redirect_pc}, 64'd0);
      check_output("async_reset_rs1_x3", {32'b0, rs1_data}, 64'd0);
      #1;
      rstn = 1'b1;

      // Counter wrap from all-ones
      @(negedge clk);
      force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut.instret;
      #1;
      check_output("instret_preset_all_ones", instret, 64'hFFFF_FFFF_FFFF_FFFF);
      apply_stimulus(1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      idle();
      #1;
      check_output("instret_wraps_to_zero", instret, 64'd0);

      // Ten back-to-back commits
      apply_stimulus(1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
      repeat (10) @(posedge clk);
      #1;
      idle();
      check_output("instret_after_ten", instret, 64'd10);
      check_output("commit_valid_after_ten", {63'b0, commit_valid}, 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
